divisor_seq: RTL and testbench
==============================

Name: divisor_seq

Overview:
Parametrised multi-cycle integer divider. It is the next generation of the fixed 8-bit combinational divider used in `system`. It supports any operand width, signed and unsigned modes, a start/busy/done handshake, and divide-by-zero and overflow flags. It runs one restoring shift-subtract step per clock. It sits between the operand sources (`i_a`/`i_b` in `system`) and the result consumers (LED/UART reporting).

Parameters:
- p_N, 8, operand/result width in bits (≥2).
- p_SIGNED_EN, 1, 1 = signed mode selectable via `i_signed`; 0 = `i_signed` ignored, always unsigned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset: rst=0 resets immediately, release is synchronous to clk.
- i_start  in  1  start request; sampled on rising edge.
- i_signed  in  1  1 = two's-complement operands; latched with `i_start`.
- i_a  in  p_N  dividend; latched with `i_start`.
- i_b  in  p_N  divisor; latched with `i_start`.
- o_q  out  p_N  quotient.
- o_r  out  p_N  remainder.
- o_busy  out  1  division in progress.
- o_done  out  1  one-cycle pulse: results valid.
- o_div0  out  1  last division had divisor zero; held with results.
- o_ovf  out  1  last division was signed MIN / -1; held with results.

Behaviour:
- **Reset (rst=0, any time, including mid-operation):** state=IDLE; o_q, o_r = 0; o_busy, o_done, o_div0, o_ovf = 0. The operation in progress is discarded.
- **States:**
  - IDLE: waiting for a start.
  - CALC: p_N iterations.
  - FIX: sign correction and result register write.
  - DONE: one cycle, o_done=1.
  - DONE → IDLE automatically.
- **Start acceptance:**
  - i_start is accepted only in IDLE or DONE (o_busy=0).
  - A start asserted while o_busy=1 is ignored, with no effect on the running operation.
- **Accept at edge E0:**
  - Latch operands and mode.
  - Clear o_div0 and o_ovf.
  - o_busy=1 after E0.
  - In signed mode, operands are converted to magnitudes and the result signs are stored.
- **Normal latency:**
  - CALC spans edges E1..Ep_N.
  - FIX occurs at edge E(p_N+1): o_q and o_r are registered and o_busy is cleared.
  - o_done=1 for exactly one cycle, the cycle following E(p_N+1).
  - For p_N=8, o_done is high in the 10th cycle after start.
- **Divide by zero (i_b=0 at accept):**
  - CALC is skipped; go directly to FIX.
  - o_q = all ones, o_r = i_a (unmodified, in either mode), o_div0=1.
  - o_done is high in the cycle after E1.
- **Signed overflow (i_signed=1, i_a=MIN, i_b=-1):**
  - Run the normal path.
  - o_q = MIN (wrapped), o_r = 0, o_ovf=1.
  - Same latency as the normal path.
- **Arithmetic:**
  - Unsigned: q = floor(a/b), r = a - q·b.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend; |r| < |b|.
  - Internal partial remainder is p_N+1 bits; magnitudes of MIN are handled as unsigned p_N-bit values.
- **Result holding:** o_q, o_r, o_div0 and o_ovf hold their values until the next accepted start or reset. They do not change during CALC; the result registers update only in FIX.
- **Back-to-back:** a start asserted in the DONE cycle is accepted. o_busy rises the next cycle, with no idle gap required.

Decomposition:
- **Shared package `divisor_pkg`:** state encoding constants (IDLE, CALC, FIX, DONE) and the iteration-counter width function clog2(p_N+1).
- **Sub-module `divisor_step`:** combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new remainder and quotient bit.
  - The top level holds the FSM, counter, sign handling and output registers.

Test Plan:
1. **Unsigned exact, p_N=8:** a=14, b=7, i_signed=0, start → o_q=2, o_r=0, flags 0, o_done pulse in the 10th cycle after start, o_busy high for cycles 1..9.
2. **Unsigned with remainder:** a=255, b=16 → o_q=15, o_r=15. Then a=3, b=200 → o_q=0, o_r=3.
3. **Signed, all sign combinations, p_N=8:**
   - -7/2 → q=0xFD (-3), r=0xFF (-1).
   - 7/-2 → q=0xFD, r=0x01.
   - -7/-2 → q=0x03, r=0xFF.
   - -128/-1 → q=0x80, r=0x00, o_ovf=1.
4. **Divide by zero:** a=0x5A, b=0 (signed and unsigned) → o_q=0xFF, o_r=0x5A, o_div0=1, o_done in the 2nd cycle after start. The flag clears on the next start.
5. **Handshake:**
   - Start pulsed again mid-CALC with different operands → ignored; the first result is unchanged.
   - Start in the DONE cycle → second division accepted, its o_done 10 cycles later.
6. **Reset and width:**
   - rst=0 asserted mid-CALC → all outputs 0 immediately (asynchronously). After release, a new division completes correctly.
   - Repeat with p_N=16: a=50000, b=7 → q=7142, r=6, o_done in the 18th cycle.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// iteration-counter width helper.
package divisor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter must hold 0..n, so it needs clog2(n+1) bits.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divisor_step.sv
// One combinational restoring shift-subtract step on a p_N+1 bit partial remainder.
module divisor_step #(
    parameter int p_N = 8
) (
    input  logic [p_N:0]   rem_in,
    input  logic           next_bit,
    input  logic [p_N-1:0] divisor,
    output logic [p_N:0]   rem_out,
    output logic           q_bit
);

    logic [p_N+1:0] shifted;
    logic [p_N+1:0] diff;

    // A borrow out of the widened subtraction means the divisor did not fit.
    always_comb begin
        shifted = {rem_in, next_bit};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[p_N+1];
        rem_out = q_bit ? diff[p_N:0] : shifted[p_N:0];
    end

endmodule

// File: rtl/divisor_seq.sv
// Multi-cycle restoring integer divider, signed or unsigned, one quotient bit
// per clock, with start/busy/done handshake and divide-by-zero/overflow flags.
module divisor_seq
    import divisor_pkg::*;
#(
    parameter int p_N         = 8,
    parameter int p_SIGNED_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_signed,
    input  logic [p_N-1:0] i_a,
    input  logic [p_N-1:0] i_b,
    output logic [p_N-1:0] o_q,
    output logic [p_N-1:0] o_r,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_div0,
    output logic           o_ovf
);

    localparam int CW = cnt_width(p_N);

    state_t         state, next_state;
    logic [CW-1:0]  cnt;
    logic [p_N-1:0] dvd;
    logic [p_N-1:0] dsr;
    logic [p_N-1:0] quo;
    logic [p_N:0]   rem;
    logic [p_N-1:0] a_raw;
    logic           q_neg;
    logic           r_neg;
    logic           is_div0;
    logic           is_ovf;

    logic           accept;
    logic           sgn;
    logic           a_neg;
    logic           b_neg;
    logic [p_N-1:0] a_mag;
    logic [p_N-1:0] b_mag;
    logic           ovf_case;
    logic [p_N:0]   step_rem;
    logic           step_q;

    divisor_step #(.p_N(p_N)) u_step (
        .rem_in   (rem),
        .next_bit (dvd[p_N-1]),
        .divisor  (dsr),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    assign o_busy = (state == ST_CALC) || (state == ST_FIX);
    assign o_done = (state == ST_DONE);

    // Operand conditioning; magnitude of MIN stays correct as an unsigned value.
    always_comb begin
        accept     = i_start && ((state == ST_IDLE) || (state == ST_DONE));
        sgn        = (p_SIGNED_EN != 0) && i_signed;
        a_neg      = sgn && i_a[p_N-1];
        b_neg      = sgn && i_b[p_N-1];
        a_mag      = a_neg ? -i_a : i_a;
        b_mag      = b_neg ? -i_b : i_b;
        ovf_case   = sgn && (i_a == {1'b1, {(p_N-1){1'b0}}}) && (&i_b);
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (i_start)
                    next_state = (i_b == '0) ? ST_FIX : ST_CALC;
                else
                    next_state = ST_IDLE;
            end
            ST_CALC: if (cnt == CW'(p_N - 1)) next_state = ST_FIX;
            ST_FIX:  next_state = ST_DONE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Datapath: latch on accept, iterate in CALC, publish results only in FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            dvd     <= '0;
            dsr     <= '0;
            quo     <= '0;
            rem     <= '0;
            a_raw   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            is_div0 <= 1'b0;
            is_ovf  <= 1'b0;
            o_q     <= '0;
            o_r     <= '0;
            o_div0  <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            dvd     <= a_mag;
            dsr     <= b_mag;
            quo     <= '0;
            rem     <= '0;
            a_raw   <= i_a;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            is_div0 <= (i_b == '0);
            is_ovf  <= ovf_case;
            o_div0  <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (state == ST_CALC) begin
            cnt <= cnt + 1'b1;
            dvd <= {dvd[p_N-2:0], 1'b0};
            quo <= {quo[p_N-2:0], step_q};
            rem <= step_rem;
        end else if (state == ST_FIX) begin
            if (is_div0) begin
                o_q    <= '1;
                o_r    <= a_raw;
                o_div0 <= 1'b1;
            end else begin
                o_q   <= q_neg ? -quo : quo;
                o_r   <= r_neg ? -rem[p_N-1:0] : rem[p_N-1:0];
                o_ovf <= is_ovf;
            end
        end
    end

endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq: an arithmetic reference model tracks the
// 8-bit instance every cycle, directed runs pin the spec examples on 8 and 16 bits.
module tb_divisor_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, signed8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  q8, r8;
    logic        busy8, done8, div08, ovf8;

    logic        start16 = 1'b0, signed16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [15:0] q16, r16;
    logic        busy16, done16, div016, ovf16;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    divisor_seq #(.p_N(8), .p_SIGNED_EN(1)) dut8 (
        .clk(clk), .rst(rst), .i_start(start8), .i_signed(signed8),
        .i_a(a8), .i_b(b8), .o_q(q8), .o_r(r8),
        .o_busy(busy8), .o_done(done8), .o_div0(div08), .o_ovf(ovf8)
    );

    divisor_seq #(.p_N(16), .p_SIGNED_EN(1)) dut16 (
        .clk(clk), .rst(rst), .i_start(start16), .i_signed(signed16),
        .i_a(a16), .i_b(b16), .o_q(q16), .o_r(r16),
        .o_busy(busy16), .o_done(done16), .o_div0(div016), .o_ovf(ovf16)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference division straight from the arithmetic definition, n-bit operands.
    task automatic model_div(input int n, input logic [15:0] a, input logic [15:0] b,
                             input bit s, output logic [15:0] q, output logic [15:0] r,
                             output bit d0, output bit ov);
        longint full, half, sa, sb, qq, rr;
        full = longint'(1) << n;
        half = full / 2;
        sa = longint'(a);
        sb = longint'(b);
        if (s) begin
            if (sa >= half) sa = sa - full;
            if (sb >= half) sb = sb - full;
        end
        d0 = (b == 16'd0);
        ov = s && (sa == -half) && (sb == -1);
        if (d0) begin
            q = 16'(full - 1);
            r = a;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q = 16'(qq & (full - 1));
            r = 16'(rr & (full - 1));
        end
    endtask

    bit         m_busy = 0, m_done = 0, m_div0 = 0, m_ovf = 0;
    logic [7:0] m_q = '0, m_r = '0;
    int         m_left = 0;
    logic [15:0] p_q, p_r;
    bit          p_d0, p_ov;

    // Cycle-level model of the 8-bit instance: compare, then advance over the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_div0 = 0; m_ovf = 0;
            m_q = '0; m_r = '0; m_left = 0;
        end
        checkOutput("busy", {63'd0, busy8}, {63'd0, m_busy});
        checkOutput("done", {63'd0, done8}, {63'd0, m_done});
        checkOutput("div0", {63'd0, div08}, {63'd0, m_div0});
        checkOutput("ovf",  {63'd0, ovf8},  {63'd0, m_ovf});
        checkOutput("q",    {56'd0, q8},    {56'd0, m_q});
        checkOutput("r",    {56'd0, r8},    {56'd0, m_r});
        if (rst) begin
            m_done = 0;
            if (!m_busy && start8) begin
                model_div(8, {8'h00, a8}, {8'h00, b8}, signed8, p_q, p_r, p_d0, p_ov);
                m_busy = 1; m_div0 = 0; m_ovf = 0;
                m_left = p_d0 ? 1 : 9;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_q = p_q[7:0]; m_r = p_r[7:0];
                    m_div0 = p_d0; m_ovf = p_ov;
                end
            end
        end
    end

    // Issue one division and wait (bounded) for its done pulse; returns in the done cycle.
    task automatic applyStimulus(input bit wide, input bit now, input bit interfere,
                                 input logic [15:0] a, input logic [15:0] b, input bit s,
                                 input logic [15:0] exp_q, input logic [15:0] exp_r,
                                 input bit exp_d0, input bit exp_ov, input int exp_lat,
                                 input string tag);
        int lat;
        if (!now) begin
            @(posedge clk); #2;
        end
        if (wide) begin
            a16 = a; b16 = b; signed16 = s; start16 = 1'b1;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; signed8 = s; start8 = 1'b1;
        end
        @(posedge clk); #2;
        start8 = 1'b0; start16 = 1'b0;
        lat = 1;
        while (!(wide ? done16 : done8) && lat < 40) begin
            @(posedge clk); #2;
            lat++;
            if (interfere) begin
                start8 = (lat == 3);
                a8 = 8'h11; b8 = 8'h03;
            end
        end
        start8 = 1'b0;
        checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, " q"},    wide ? {48'd0, q16} : {56'd0, q8}, {48'd0, exp_q});
        checkOutput({tag, " r"},    wide ? {48'd0, r16} : {56'd0, r8}, {48'd0, exp_r});
        checkOutput({tag, " div0"}, {63'd0, wide ? div016 : div08}, {63'd0, exp_d0});
        checkOutput({tag, " ovf"},  {63'd0, wide ? ovf16 : ovf8},   {63'd0, exp_ov});
    endtask

    initial begin
        logic [15:0] eq, er, ra, rb;
        bit ed0, eov;

        #1 rst = 1'b0;
        #1;
        checkOutput("reset q",    {56'd0, q8},     64'd0);
        checkOutput("reset r",    {56'd0, r8},     64'd0);
        checkOutput("reset busy", {63'd0, busy8},  64'd0);
        checkOutput("reset done", {63'd0, done8},  64'd0);
        checkOutput("reset q16",  {48'd0, q16},    64'd0);

        model_div(8, 16'd14, 16'd7, 0, eq, er, ed0, eov);
        checkOutput("model 14/7", {32'd0, eq, er}, {32'd0, 16'd2, 16'd0});
        model_div(8, 16'h00F9, 16'h0002, 1, eq, er, ed0, eov);
        checkOutput("model -7/2", {32'd0, eq, er}, {32'd0, 16'h00FD, 16'h00FF});
        model_div(8, 16'h0080, 16'h00FF, 1, eq, er, ed0, eov);
        checkOutput("model ovf", {31'd0, eov, eq, er}, {31'd0, 1'b1, 16'h0080, 16'h0000});
        model_div(16, 16'd50000, 16'd7, 0, eq, er, ed0, eov);
        checkOutput("model 16b", {32'd0, eq, er}, {32'd0, 16'd7142, 16'd6});

        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        applyStimulus(0, 0, 0, 16'd14,  16'd7,   0, 16'd2,   16'd0,   0, 0, 10, "u 14/7");
        applyStimulus(0, 0, 0, 16'd255, 16'd16,  0, 16'd15,  16'd15,  0, 0, 10, "u 255/16");
        applyStimulus(0, 0, 0, 16'd3,   16'd200, 0, 16'd0,   16'd3,   0, 0, 10, "u 3/200");
        applyStimulus(0, 0, 0, 16'hF9,  16'h02,  1, 16'hFD,  16'hFF,  0, 0, 10, "s -7/2");
        applyStimulus(0, 0, 0, 16'h07,  16'hFE,  1, 16'hFD,  16'h01,  0, 0, 10, "s 7/-2");
        applyStimulus(0, 0, 0, 16'hF9,  16'hFE,  1, 16'h03,  16'hFF,  0, 0, 10, "s -7/-2");
        applyStimulus(0, 0, 0, 16'h80,  16'hFF,  1, 16'h80,  16'h00,  0, 1, 10, "s min/-1");
        applyStimulus(0, 0, 0, 16'h5A,  16'h00,  1, 16'hFF,  16'h5A,  1, 0, 2,  "s div0");
        applyStimulus(0, 0, 0, 16'h5A,  16'h00,  0, 16'hFF,  16'h5A,  1, 0, 2,  "u div0");
        applyStimulus(0, 0, 0, 16'd9,   16'd4,   0, 16'd2,   16'd1,   0, 0, 10, "div0 clear");
        applyStimulus(0, 0, 1, 16'd100, 16'd9,   0, 16'd11,  16'd1,   0, 0, 10, "ignore mid");
        applyStimulus(0, 0, 0, 16'd100, 16'd9,   0, 16'd11,  16'd1,   0, 0, 10, "b2b first");
        applyStimulus(0, 1, 0, 16'h9C,  16'd9,   1, 16'hF5,  16'hFF,  0, 0, 10, "b2b second");

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #2;
        a8 = 8'd200; b8 = 8'd3; signed8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        checkOutput("pre-rst busy", {63'd0, busy8}, 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("rst busy", {63'd0, busy8}, 64'd0);
        checkOutput("rst done", {63'd0, done8}, 64'd0);
        checkOutput("rst q",    {56'd0, q8},    64'd0);
        checkOutput("rst r",    {56'd0, r8},    64'd0);
        checkOutput("rst div0", {63'd0, div08}, 64'd0);
        checkOutput("rst ovf",  {63'd0, ovf8},  64'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 16'd200, 16'd3, 0, 16'd66, 16'd2, 0, 0, 10, "after rst");

        applyStimulus(1, 0, 0, 16'd50000, 16'd7, 0, 16'd7142, 16'd6, 0, 0, 18, "w 50000/7");
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = (i == 2) ? 16'd0 : ((i == 3) ? 16'hFFFF : 16'($urandom));
            if (i == 3) ra = 16'h8000;
            model_div(16, ra, rb, i[0], eq, er, ed0, eov);
            applyStimulus(1, 0, 0, ra, rb, i[0], eq, er, ed0, eov, ed0 ? 2 : 18, "w rand");
        end

        // Random traffic on the 8-bit instance, including starts while busy.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            start8  = ($urandom_range(0, 3) == 0);
            signed8 = 1'($urandom_range(0, 1));
            a8      = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       b8 = 8'h00;
                1:       begin a8 = 8'h80; b8 = 8'hFF; end
                default: b8 = 8'($urandom);
            endcase
        end
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
